// File: rtl/vdp_cpu_if.sv
// ---------------------------------------------------------------------------
// vdp_cpu_if
//
// This block is the CPU-side port interface of the video display processor.
// It sits between the Z80 I/O decode and the video core. It provides:
//   - the two-byte address/register latch on the control port,
//   - a VRAM read-ahead buffer whose address auto-increments,
//   - the status register, with flags that clear when it is read,
//   - interrupt generation,
//   - a one-entry pending slot in front of a req/ack VRAM handshake.
//
// Parameters
//   NUM_REGS  number of control registers (8..64)
//   VRAM_AW   VRAM address width (14..17); bits above 13 come from R14
//
// Optional feature (macro VDP_INDIRECT_EN)
//   When defined, a write to port 3 stores a byte to R[R17[5:0]]. R17 then
//   auto-increments unless R17[7] is set. When the macro is not defined,
//   port 3 is ignored.
//
// Ports
//   clk, reset_n         clock and asynchronous active-low reset
//   io_sel               chip select for the VDP port block
//   io_port[1:0]         0 data, 1 control/status, 3 indirect
//   io_wr, io_rd         single-cycle strobes, qualified by io_sel
//   din[7:0]             CPU write data
//   dout[7:0]            CPU read data, combinational from io_port
//   wait_n               low while a VRAM operation is queued or in flight
//   vram_req/we/addr/    VRAM request; held stable until vram_ack
//     wdata
//   vram_rdata, vram_ack read data and single-cycle completion
//   vblank, coll, fifth  status flag set pulses; fifth_num is the sprite number
//   regs                 flat register file, R0 in [7:0]
//   n_int                active-low interrupt
// ---------------------------------------------------------------------------
module vdp_cpu_if #(
  parameter int NUM_REGS = 8,
  parameter int VRAM_AW  = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  io_sel,
  input  logic [1:0]            io_port,
  input  logic                  io_wr,
  input  logic                  io_rd,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  wait_n,
  output logic                  vram_req,
  output logic                  vram_we,
  output logic [VRAM_AW-1:0]    vram_addr,
  output logic [7:0]            vram_wdata,
  input  logic [7:0]            vram_rdata,
  input  logic                  vram_ack,
  input  logic                  vblank,
  input  logic                  coll,
  input  logic                  fifth,
  input  logic [4:0]            fifth_num,
  output logic [NUM_REGS*8-1:0] regs,
  output logic                  n_int
);

  localparam int        HIW     = VRAM_AW - 14;
  localparam logic [2:0] HI_MASK = 3'((1 << HIW) - 1);
  localparam bit        HAS_HI  = (VRAM_AW > 14) && (NUM_REGS > 14);

  typedef enum logic {LATCH_FIRST, LATCH_SECOND} latch_e;
  typedef enum logic {VRAM_IDLE, VRAM_BUSY} vram_e;

  latch_e              latch_q, latch_d;
  vram_e               vstate_q, vstate_d;
  logic [7:0]          tmpByte_q, tmpByte_d;
  logic [13:0]         addr_q, addr_d;
  logic [7:0]          rdBuf_q, rdBuf_d;
  logic                flagF_q, flagF_d;
  logic                flag5s_q, flag5s_d;
  logic                flagC_q, flagC_d;
  logic [4:0]          fifthNum_q, fifthNum_d;
  logic [7:0]          regs_q [NUM_REGS];
  logic [7:0]          regs_d [NUM_REGS];
  logic                curWe_q, curWe_d;
  logic [VRAM_AW-1:0]  curAddr_q, curAddr_d;
  logic [7:0]          curData_q, curData_d;
  logic                pend_q, pend_d;
  logic                pendWe_q, pendWe_d;
  logic [7:0]          pendData_q, pendData_d;
  logic                addrDirty_q, addrDirty_d;

  logic                wr0, rd0, wr1, rd1;
  logic                ctrlRegWr, addrSet, ackHit, carry;
  logic                newOp, newWe;
  logic [7:0]          newData;
  logic [2:0]          hiBits;
  logic                r1Ie;
  logic [VRAM_AW-1:0]  launchAddr;
`ifdef VDP_INDIRECT_EN
  logic                wr3;
  logic [5:0]          indIdx;
  logic                indHold;
`endif

  assign wr0 = io_sel & io_wr & (io_port == 2'd0);
  assign rd0 = io_sel & io_rd & (io_port == 2'd0);
  assign wr1 = io_sel & io_wr & (io_port == 2'd1);
  assign rd1 = io_sel & io_rd & (io_port == 2'd1);
`ifdef VDP_INDIRECT_EN
  assign wr3 = io_sel & io_wr & (io_port == 2'd3);
`endif

  // Pick out the few register fields that have a hardware function. Registers
  // that do not exist for a small NUM_REGS read as zero.
  always_comb begin
    hiBits  = 3'b000;
    r1Ie    = 1'b0;
`ifdef VDP_INDIRECT_EN
    indIdx  = 6'd0;
    indHold = 1'b0;
`endif
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == 1) r1Ie = regs_q[i][5];
      if (HAS_HI && i == 14) hiBits = regs_q[i][2:0] & HI_MASK;
`ifdef VDP_INDIRECT_EN
      if (i == 17) begin
        indIdx  = regs_q[i][5:0];
        indHold = regs_q[i][7];
      end
`endif
    end
  end

  // CPU port decode: the control latch, address updates, register writes,
  // status flags, and the VRAM op queue.
  always_comb begin
    latch_d     = latch_q;
    vstate_d    = vstate_q;
    tmpByte_d   = tmpByte_q;
    addr_d      = addr_q;
    rdBuf_d     = rdBuf_q;
    flagF_d     = flagF_q;
    flag5s_d    = flag5s_q;
    flagC_d     = flagC_q;
    fifthNum_d  = fifthNum_q;
    regs_d      = regs_q;
    curWe_d     = curWe_q;
    curAddr_d   = curAddr_q;
    curData_d   = curData_q;
    pend_d      = pend_q;
    pendWe_d    = pendWe_q;
    pendData_d  = pendData_q;
    addrDirty_d = addrDirty_q;
    ctrlRegWr   = 1'b0;
    addrSet     = 1'b0;
    newOp       = 1'b0;
    newWe       = 1'b0;
    newData     = 8'h00;
    carry       = 1'b0;
    launchAddr  = '0;

    if (wr1) begin
      if (latch_q == LATCH_FIRST) begin
        tmpByte_d = din;
        latch_d   = LATCH_SECOND;
      end else begin
        latch_d = LATCH_FIRST;
        if (din[7]) begin
          ctrlRegWr = 1'b1;
        end else begin
          addrSet = 1'b1;
          if (!din[6]) newOp = 1'b1;
        end
      end
    end
    if (wr0 || rd0 || rd1) latch_d = LATCH_FIRST;
    if (wr0) begin
      newOp   = 1'b1;
      newWe   = 1'b1;
      newData = din;
    end
    if (rd0) newOp = 1'b1;

    // A completed write also refreshes the read-ahead buffer. After an
    // address setup that happened while an op was in flight, the completing
    // op must not bump the freshly loaded address.
    ackHit = (vstate_q == VRAM_BUSY) && vram_ack;
    if (ackHit) begin
      rdBuf_d = curWe_q ? curData_q : vram_rdata;
      if (!addrDirty_q) {carry, addr_d} = {1'b0, addr_q} + 15'd1;
    end
    if (addrSet) begin
      addr_d = {din[5:0], tmpByte_q};
      carry  = 1'b0;
    end

    for (int i = 0; i < NUM_REGS; i++) begin
      if (HAS_HI && i == 14 && carry)
        regs_d[i] = (regs_q[i] & ~{5'b0, HI_MASK}) |
                    ({5'b0, 3'(regs_q[i][2:0] + 3'd1)} & {5'b0, HI_MASK});
`ifdef VDP_INDIRECT_EN
      if (wr3 && i[5:0] == indIdx && i != 17) regs_d[i] = din;
      if (wr3 && i == 17 && !indHold) regs_d[i] = {regs_q[i][7:6], indIdx + 6'd1};
`endif
      if (ctrlRegWr && i[5:0] == din[5:0]) regs_d[i] = tmpByte_q;
    end

    // A set pulse that arrives in the same cycle as a status read wins over
    // the clear, so no event is lost.
    if (rd1) begin
      flagF_d  = 1'b0;
      flag5s_d = 1'b0;
      flagC_d  = 1'b0;
    end
    if (vblank) flagF_d = 1'b1;
    if (coll) flagC_d = 1'b1;
    if (fifth) begin
      flag5s_d = 1'b1;
      if (!flag5s_q) fifthNum_d = fifth_num;
    end

    // The address is taken when the op is launched. A queued op therefore
    // sees the increment from the op ahead of it.
    launchAddr = VRAM_AW'({hiBits, addr_d});
    case (vstate_q)
      VRAM_IDLE: begin
        if (pend_q) begin
          vstate_d    = VRAM_BUSY;
          curWe_d     = pendWe_q;
          curData_d   = pendData_q;
          curAddr_d   = launchAddr;
          addrDirty_d = 1'b0;
          pend_d      = newOp;
          pendWe_d    = newWe;
          pendData_d  = newData;
        end else if (newOp) begin
          vstate_d    = VRAM_BUSY;
          curWe_d     = newWe;
          curData_d   = newData;
          curAddr_d   = launchAddr;
          addrDirty_d = 1'b0;
        end
      end
      VRAM_BUSY: begin
        if (ackHit) vstate_d = VRAM_IDLE;
        if (addrSet && !ackHit) addrDirty_d = 1'b1;
        if (newOp && !pend_q) begin
          pend_d     = 1'b1;
          pendWe_d   = newWe;
          pendData_d = newData;
        end
      end
      default: vstate_d = VRAM_IDLE;
    endcase
  end

  // State registers. Reset drops any in-flight request at once, so a late
  // ack finds the FSM idle and is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch_q     <= LATCH_FIRST;
      vstate_q    <= VRAM_IDLE;
      tmpByte_q   <= 8'h00;
      addr_q      <= 14'd0;
      rdBuf_q     <= 8'h00;
      flagF_q     <= 1'b0;
      flag5s_q    <= 1'b0;
      flagC_q     <= 1'b0;
      fifthNum_q  <= 5'd0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
      curWe_q     <= 1'b0;
      curAddr_q   <= '0;
      curData_q   <= 8'h00;
      pend_q      <= 1'b0;
      pendWe_q    <= 1'b0;
      pendData_q  <= 8'h00;
      addrDirty_q <= 1'b0;
    end else begin
      latch_q     <= latch_d;
      vstate_q    <= vstate_d;
      tmpByte_q   <= tmpByte_d;
      addr_q      <= addr_d;
      rdBuf_q     <= rdBuf_d;
      flagF_q     <= flagF_d;
      flag5s_q    <= flag5s_d;
      flagC_q     <= flagC_d;
      fifthNum_q  <= fifthNum_d;
      regs_q      <= regs_d;
      curWe_q     <= curWe_d;
      curAddr_q   <= curAddr_d;
      curData_q   <= curData_d;
      pend_q      <= pend_d;
      pendWe_q    <= pendWe_d;
      pendData_q  <= pendData_d;
      addrDirty_q <= addrDirty_d;
    end
  end

  // Output assembly: read mux, handshake outputs, interrupt and flat regs.
  always_comb begin
    case (io_port)
      2'd0:    dout = rdBuf_q;
      2'd1:    dout = {flagF_q, flag5s_q, flagC_q, flag5s_q ? fifthNum_q : 5'h1F};
      default: dout = 8'hFF;
    endcase
    for (int i = 0; i < NUM_REGS; i++) regs[i*8 +: 8] = regs_q[i];
  end

  assign vram_req   = (vstate_q == VRAM_BUSY);
  assign vram_we    = curWe_q;
  assign vram_addr  = curAddr_q;
  assign vram_wdata = curData_q;
  assign wait_n     = !((vstate_q == VRAM_BUSY) || pend_q);
  assign n_int      = !(flagF_q & r1Ie);

endmodule
